// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// Load funct3 codes, low-aligned store strobes, FSM state type.
package dmem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [3:0] WE_B = 4'b0001;
    localparam logic [3:0] WE_H = 4'b0011;
    localparam logic [3:0] WE_W = 4'b1111;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

endpackage

// File: rtl/data_mem_array.sv
// Byte-lane writable, synchronous-read single-port RAM.
// Ports: clk, en (access), we[3:0] lane writes, addr word index, wdata, rdata (registered).
module data_mem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Read-first: rdata returns the pre-write word on a store access.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request per handshake, one response per request.
// Ports: clk, reset (sync, active-low), req_* request channel, rsp_* response channel.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [3:0]  req_we_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_funct3_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t      state;
    logic        accept;
    logic        is_store;
    logic        oor;
    logic        bad;
    logic        err_c;
    logic [1:0]  off;
    logic [3:0]  lane_we;
    logic [31:0] lane_wdata;
    logic [31:0] rd_raw;
    logic [31:0] shifted;
    logic [31:0] fmt;

    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        load_q;
    logic        err_q;

    assign req_ready_o = (state == IDLE) | rsp_ready_i;
    assign accept      = req_valid_i & req_ready_o;
    assign is_store    = |req_we_i;
    assign off         = req_addr_i[1:0];
    assign oor         = |req_addr_i[31:AW+2];
    assign lane_we     = req_we_i << off;
    assign lane_wdata  = req_wdata_i << {off, 3'b000};

    always_comb begin
        bad = 1'b0;
        if (is_store) begin
            unique case (req_we_i)
                WE_B:    bad = 1'b0;
                WE_H:    bad = off[0];
                WE_W:    bad = |off;
                default: bad = 1'b1;
            endcase
        end else begin
            unique case (req_funct3_i)
                LB, LBU: bad = 1'b0;
                LH, LHU: bad = off[0];
                LW:      bad = |off;
                default: bad = 1'b1;
            endcase
        end
    end

    assign err_c = bad | oor;

    // Erroring requests never touch the array.
    data_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .en    (accept & ~err_c),
        .we    (is_store ? lane_we : 4'b0000),
        .addr  (req_addr_i[AW+1:2]),
        .wdata (lane_wdata),
        .rdata (rd_raw)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            off_q  <= 2'b00;
            f3_q   <= 3'b000;
            load_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                state  <= RESP;
                off_q  <= off;
                f3_q   <= req_funct3_i;
                load_q <= ~is_store;
                err_q  <= err_c;
            end else if (rsp_ready_i) begin
                state  <= IDLE;
            end
        end
    end

    // rd_raw only changes on an accepted access, so the formatted
    // data stays stable while the response is backpressured.
    assign shifted = rd_raw >> {off_q, 3'b000};

    always_comb begin
        fmt = 32'h0;
        unique case (f3_q)
            LB:      fmt = {{24{shifted[7]}}, shifted[7:0]};
            LH:      fmt = {{16{shifted[15]}}, shifted[15:0]};
            LW:      fmt = shifted;
            LBU:     fmt = {24'h0, shifted[7:0]};
            LHU:     fmt = {16'h0, shifted[15:0]};
            default: fmt = 32'h0;
        endcase
    end

    assign rsp_valid_o = (state == RESP);
    assign rsp_err_o   = rsp_valid_o & err_q;
    assign rsp_rdata_o = (rsp_valid_o & load_q & ~err_q) ? fmt : 32'h0;

endmodule
